// File: rtl/ipd_pkg.sv
//------------------------------------------------------------------------------
// Module   : ipd_pkg
// Brief    : Shared constants, FSM encoding and timing legality check for the
//            IPD sample scheduler and its companion stages.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ipd_pkg;

  localparam int c_DEF_CANT_BITS = 16;
  localparam int c_DEF_FRAC_BITS = 8;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_REQ   = 3'd1;
  localparam logic [2:0] c_ST_LOAD  = 3'd2;
  localparam logic [2:0] c_ST_WAIT  = 3'd3;
  localparam logic [2:0] c_ST_STORE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_REQ   = c_ST_REQ,
    ST_LOAD  = c_ST_LOAD,
    ST_WAIT  = c_ST_WAIT,
    ST_STORE = c_ST_STORE
  } ipd_state_t;

  // The period must fit a full zero-wait sample plus margin, and the WAIT
  // phase needs at least one cycle.
  function automatic bit ipd_timing_ok(input int sample_div, input int ipd_lat);
    return (ipd_lat >= 2) && (sample_div > ipd_lat + 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ipd_sat_trunc.sv
//------------------------------------------------------------------------------
// Module   : ipd_sat_trunc
// Brief    : Drops FRAC_BITS fractional bits (floor) from a double-width signed
//            value and clamps the result to cant_bits signed.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ipd_sat_trunc
  import ipd_pkg::*;
#(
  parameter int cant_bits = c_DEF_CANT_BITS,
  parameter int FRAC_BITS = c_DEF_FRAC_BITS
) (
  input  logic signed [2*cant_bits-1:0] i_yk,
  output logic signed [cant_bits-1:0]   o_u,
  output logic                          o_sat
);

  localparam int c_IN_W = 2 * cant_bits;

  logic signed [c_IN_W-1:0]         w_shift;
  logic        [c_IN_W-cant_bits:0] w_top;

  assign w_shift = i_yk >>> FRAC_BITS;
  // The value fits only if every bit from the output sign bit upward agrees.
  assign w_top   = w_shift[c_IN_W-1:cant_bits-1];

  always_comb begin
    o_sat = !((&w_top) || !(|w_top));
    o_u   = w_shift[cant_bits-1:0];
    if (o_sat) begin
      o_u = w_shift[c_IN_W-1] ? {1'b1, {(cant_bits-1){1'b0}}}
                              : {1'b0, {(cant_bits-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ipd_sample_scheduler.sv
//------------------------------------------------------------------------------
// Module   : ipd_sample_scheduler
// Brief    : Fixed-rate sample scheduler: ADC fetch, IPD start strobe, result
//            capture and saturation to the actuator width.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ipd_sample_scheduler
  import ipd_pkg::*;
#(
  parameter int cant_bits  = c_DEF_CANT_BITS,
  parameter int SAMPLE_DIV = 1000,
  parameter int IPD_LAT    = 15,
  parameter int FRAC_BITS  = c_DEF_FRAC_BITS
) (
  input  logic                          Clk_G,
  input  logic                          Rst_G,
  input  logic                          En,
  input  logic signed [cant_bits-1:0]   Adc_Data,
  input  logic                          Adc_Ack,
  output logic                          Adc_Req,
  output logic signed [cant_bits-1:0]   Pot,
  output logic                          Rx_En,
  input  logic signed [2*cant_bits-1:0] Yk,
  output logic signed [cant_bits-1:0]   U_Out,
  output logic                          U_Valid,
  output logic                          Sat,
  output logic                          Overrun,
  output logic                          Busy
);

  localparam int                  c_TICK_W    = $clog2(SAMPLE_DIV);
  localparam int                  c_LAT_W     = $clog2(IPD_LAT);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_DIV - 1);
  // WAIT runs while the counter walks IPD_LAT-2 down to 0: IPD_LAT-1 cycles.
  localparam logic [c_LAT_W-1:0]  c_LAT_LOAD  = c_LAT_W'(IPD_LAT - 2);

  generate
    if (!ipd_timing_ok(SAMPLE_DIV, IPD_LAT)) begin : g_bad_timing
      $error("ipd_sample_scheduler: SAMPLE_DIV must exceed IPD_LAT+4 and IPD_LAT must be >= 2");
    end
  endgenerate

  ipd_state_t                  r_state;
  ipd_state_t                  w_next;
  logic       [c_TICK_W-1:0]   r_tick_cnt;
  logic       [c_LAT_W-1:0]    r_lat_cnt;
  logic                        w_tick;
  logic signed [cant_bits-1:0] w_u;
  logic                        w_sat;

  assign w_tick = En && (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge Clk_G) begin
    if (Rst_G || !En) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == c_TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk_G) begin
    if (Rst_G) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    Adc_Req = 1'b0;
    Rx_En   = 1'b0;
    Busy    = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:  if (w_tick) w_next = ST_REQ;
      ST_REQ: begin
        Adc_Req = 1'b1;
        if (Adc_Ack) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        Rx_En  = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT:  if (r_lat_cnt == '0) w_next = ST_STORE;
      ST_STORE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  ipd_sat_trunc #(
    .cant_bits (cant_bits),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat_trunc (
    .i_yk  (Yk),
    .o_u   (w_u),
    .o_sat (w_sat)
  );

  always_ff @(posedge Clk_G) begin
    if (Rst_G) begin
      r_lat_cnt <= '0;
      Pot       <= '0;
      U_Out     <= '0;
      Sat       <= 1'b0;
      U_Valid   <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      U_Valid <= (r_state == ST_STORE);
      if (r_state == ST_REQ && Adc_Ack) begin
        Pot <= Adc_Data;
      end
      if (r_state == ST_LOAD) begin
        r_lat_cnt <= c_LAT_LOAD;
      end else if (r_state == ST_WAIT && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
      if (r_state == ST_STORE) begin
        U_Out <= w_u;
        Sat   <= w_sat;
      end
      // A tick that finds the sequencer busy is lost; remember it until reset.
      if (w_tick && r_state != ST_IDLE) begin
        Overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ipd_sample_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_ipd_sample_scheduler
// Brief    : Self-checking bench for ipd_sample_scheduler against a timeline model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ipd_sample_scheduler;

  localparam int CB  = 16;
  localparam int DIV = 40;
  localparam int LAT = 15;
  localparam int FB  = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, ack = 1'b0;
  logic [15:0] data = '0;
  logic [31:0] yk = '0;
  logic        Adc_Req, Rx_En, U_Valid, Sat, Overrun, Busy;
  logic [15:0] Pot, U_Out;

  ipd_sample_scheduler #(
    .cant_bits(CB), .SAMPLE_DIV(DIV), .IPD_LAT(LAT), .FRAC_BITS(FB)
  ) dut (
    .Clk_G(clk), .Rst_G(rst), .En(en), .Adc_Data(data), .Adc_Ack(ack),
    .Adc_Req(Adc_Req), .Pot(Pot), .Rx_En(Rx_En), .Yk(yk), .U_Out(U_Out),
    .U_Valid(U_Valid), .Sat(Sat), .Overrun(Overrun), .Busy(Busy)
  );

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, m_cyc);
  endtask

  // ---------------- behavioural model: one sample as a timeline ----------------
  int          m_cyc = 0, m_cnt = 0, m_ack_cyc = 0;
  bit          m_in = 0, m_acked = 0, m_uv = 0, m_sat = 0, m_ovr = 0;
  logic [15:0] m_pot = '0, m_u = '0;

  task automatic sat_model(input logic [31:0] y, output logic [15:0] u, output bit s);
    longint v, q, d;
    d = longint'(1) << FB;
    v = longint'($signed(y));
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    if (q > 32767)       begin u = 16'h7FFF; s = 1; end
    else if (q < -32768) begin u = 16'h8000; s = 1; end
    else                 begin u = q[15:0];  s = 0; end
  endtask

  always @(posedge clk) begin
    bit tick, was_in;
    if (rst) begin
      m_in = 0; m_acked = 0; m_cnt = 0; m_pot = '0; m_u = '0;
      m_sat = 0; m_uv = 0; m_ovr = 0;
    end else begin
      tick   = en && (m_cnt == DIV - 1);
      m_cnt  = en ? ((m_cnt == DIV - 1) ? 0 : m_cnt + 1) : 0;
      was_in = m_in;
      m_uv   = 0;
      if (m_in && !m_acked) begin
        if (ack) begin m_acked = 1; m_ack_cyc = m_cyc; m_pot = data; end
      end else if (m_in && m_cyc == m_ack_cyc + 1 + LAT) begin
        sat_model(yk, m_u, m_sat);
        m_uv = 1;
        m_in = 0;
      end
      if (tick) begin
        if (was_in) m_ovr = 1;
        else begin m_in = 1; m_acked = 0; end
      end
    end
    m_cyc++;
  end

  // ---------------- compare process and event log ----------------
  bit          chk_en = 0, prev_req = 0;
  int          req_q[$], rx_q[$], uv_q[$];
  logic [15:0] rx_pot, uv_u;
  logic        uv_sat;

  always @(negedge clk) begin
    if (chk_en) begin
      check("adc_req", {31'b0, Adc_Req}, {31'b0, m_in && !m_acked});
      check("rx_en",   {31'b0, Rx_En},   {31'b0, m_in && m_acked && (m_cyc == m_ack_cyc + 1)});
      check("busy",    {31'b0, Busy},    {31'b0, m_in});
      check("pot",     {16'b0, Pot},     {16'b0, m_pot});
      check("u_valid", {31'b0, U_Valid}, {31'b0, m_uv});
      check("u_out",   {16'b0, U_Out},   {16'b0, m_u});
      check("sat",     {31'b0, Sat},     {31'b0, m_sat});
      check("overrun", {31'b0, Overrun}, {31'b0, m_ovr});
      if (Adc_Req && !prev_req) req_q.push_back(m_cyc);
      if (Rx_En) begin rx_q.push_back(m_cyc); rx_pot = Pot; end
      if (U_Valid) begin uv_q.push_back(m_cyc); uv_u = U_Out; uv_sat = Sat; end
    end
    prev_req = Adc_Req;
  end

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  int          ack_delay = 1, req_age = 0, stray_pct = 0;
  bit          rand_delay = 0, data_rand = 0, yk_rand = 1;
  logic [15:0] data_fix = '0;
  logic [31:0] yk_fix = '0;

  function automatic logic [31:0] rand_yk();
    logic [31:0] r;
    r = $urandom;
    r = r >> $urandom_range(0, 24);
    if ($urandom_range(0, 1) == 1) r = -r;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_delay && Adc_Req && req_age == 0)
      ack_delay = ($urandom_range(0, 9) == 0) ? $urandom_range(41, 50) : $urandom_range(0, 4);
    ack = 1'b0;
    if (Adc_Req) begin
      ack = (req_age == ack_delay);
      req_age++;
    end else begin
      req_age = 0;
      ack = ($urandom_range(0, 99) < stray_pct);
    end
    data = data_rand ? 16'($urandom) : data_fix;
    yk   = yk_rand ? rand_yk() : yk_fix;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; en = 1'b0;
    step(); rst = 1'b0;
  endtask

  logic [31:0] vec_yk[4]  = '{32'h0100_0000, 32'hFF00_0000, 32'h0000_1280, 32'hFFFF_FF80};
  logic [15:0] vec_u[4]   = '{16'h7FFF, 16'h8000, 16'h0012, 16'hFFFF};
  logic        vec_sat[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int          c0;

  initial begin
    step();
    chk_en = 1;
    step(); rst = 1'b0;

    // Nominal sample: request/strobe/result timing and period
    do_reset();
    data_fix = 16'h4B00; ack_delay = 1;
    req_q.delete(); rx_q.delete(); uv_q.delete();
    step(); en = 1'b1; c0 = m_cyc;
    repeat (85) step();
    check("s1_req_cycle",    qat(req_q, 0), c0 + 40);
    check("s1_rx_cycle",     qat(rx_q, 0),  c0 + 42);
    check("s1_pot",          {16'b0, rx_pot}, 32'h0000_4B00);
    check("s1_uvalid_cycle", qat(uv_q, 0),  c0 + 58);
    check("s1_period",       qat(req_q, 1), c0 + 80);
    check("s1_rx_count",     rx_q.size(), 2);

    // Saturation / truncation vectors
    ack_delay = 0; yk_rand = 0;
    for (int v = 0; v < 4; v++) begin
      yk_fix = vec_yk[v]; yk = yk_fix; uv_q.delete();
      for (int k = 0; k < 80 && uv_q.size() == 0; k++) step();
      check("s2_uvalid_seen", uv_q.size(), 1);
      check("s2_u_out", {16'b0, uv_u}, {16'b0, vec_u[v]});
      check("s2_sat",   {31'b0, uv_sat}, {31'b0, vec_sat[v]});
    end
    yk_rand = 1;

    // ADC stall for 50 cycles
    do_reset();
    ack_delay = 50;
    req_q.delete(); rx_q.delete(); uv_q.delete();
    step(); en = 1'b1; c0 = m_cyc;
    repeat (110) step();
    check("s3_req_rises",    req_q.size(), 1);
    check("s3_rx_count",     rx_q.size(), 1);
    check("s3_uv_count",     uv_q.size(), 1);
    check("s3_uvalid_cycle", qat(uv_q, 0), c0 + 107);
    check("s3_overrun",      {31'b0, Overrun}, 32'd1);

    // Reset five cycles after Rx_En, mid-WAIT
    ack_delay = 1; rx_q.delete();
    for (int k = 0; k < 80 && rx_q.size() == 0; k++) step();
    repeat (4) step();
    rst = 1'b1;
    step(); rst = 1'b0;
    check("s4_rst_outputs", {Adc_Req, Rx_En, U_Valid, Sat, Overrun, Busy, Pot, U_Out}, 32'd0);
    uv_q.delete();
    repeat (30) step();
    check("s4_no_uvalid", uv_q.size(), 0);

    // En drops during WAIT
    data_fix = 16'h0ABC; rx_q.delete();
    for (int k = 0; k < 80 && rx_q.size() == 0; k++) step();
    repeat (3) step();
    en = 1'b0; req_q.delete(); uv_q.delete();
    repeat (200) step();
    check("s5_uvalid_count", uv_q.size(), 1);
    check("s5_no_req",       req_q.size(), 0);
    check("s5_pot",          {16'b0, Pot}, 32'h0000_0ABC);

    // Stray ack while idle
    stray_pct = 100; data_fix = 16'h1234; rx_q.delete();
    repeat (6) step();
    stray_pct = 0;
    step();
    check("s6_pot_held", {16'b0, Pot}, 32'h0000_0ABC);
    check("s6_no_rx",    rx_q.size(), 0);

    // Randomized traffic against the model
    rand_delay = 1; data_rand = 1; stray_pct = 10; en = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      step();
      if ($urandom_range(0, 299) == 0) en = ~en;
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
